alu_result_checker: RTL and testbench

- Hardware self-check block at the consuming end of the 4-bit ALU interface (a, b, opcode -> rslt).
- Samples each vector the ALU is driven with, recomputes the expected result and compares it against the ALU's rslt.
- Keeps pass/fail counts and captures the first failing vector, so ALU regression runs on silicon/FPGA without a simulator monitor.

---
 rtl/alu_result_checker.sv | 173 +++++++++++++++++
 tb/tb_alu_result_checker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// ---------------------------------------------------------------------------
// alu_result_checker
//   In-system self-check for the 4-bit ALU interface (a, b, opcode -> rslt).
//   Each accepted vector is recomputed through a 2-stage pipeline and compared
//   against the ALU's rslt.
//   The block keeps saturating pass/fail counts for the run and captures the
//   first failing vector.
//
// Optional build macro:
//   ALU_CHK_STOP_ON_FAIL_EN - the first mismatch ends the run. The vector still
//                             in stage 1 is dropped without a pulse or count.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   start, exp_count  arm a run of exp_count vectors (exp_count sampled on start)
//   chk_valid         a/b/opcode/rslt valid this cycle
//   a, b, opcode      ALU stimulus
//   rslt              ALU result under check
//   busy, done        run in progress / run complete (done held until start)
//   pass_pulse        one-cycle pulse per matching vector
//   fail_pulse        one-cycle pulse per mismatching vector
//   pass_cnt          saturating count of matching vectors this run
//   fail_cnt          saturating count of mismatching vectors this run
//   err_sticky        set on the first mismatch of the run
//   first_fail        {opcode, a, b, rslt} of the first mismatch
// ---------------------------------------------------------------------------
module alu_result_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] exp_count,
    input  logic             chk_valid,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic [2:0]       opcode,
    input  logic [7:0]       rslt,
    output logic             busy,
    output logic             done,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_sticky,
    output logic [18:0]      first_fail
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Field order matches the first_fail layout so a capture is a plain copy.
    typedef struct packed {
        logic [2:0] opcode;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] rslt;
    } vec_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Reference ALU: operands zero-extended, 8-bit wrap-around arithmetic.
    function automatic logic [7:0] alu_ref(input logic [2:0] op,
                                           input logic [3:0] x,
                                           input logic [3:0] y);
        logic [7:0] xe, ye, r;
        xe = {4'h0, x};
        ye = {4'h0, y};
        case (op)
            3'b000:  r = xe + ye;
            3'b001:  r = xe - ye;
            3'b010:  r = xe * ye;
            3'b011:  r = {4'h0, x & y};
            3'b100:  r = {4'h0, x | y};
            3'b101:  r = {4'h0, ~x};
            3'b110:  r = {4'h0, x ^ y};
            default: r = {4'h0, ~(x ^ y)};
        endcase
        return r;
    endfunction

    state_t           state, state_nxt;
    logic [CNT_W-1:0] exp_q;      // vectors expected this run
    logic [CNT_W-1:0] acc_cnt;    // vectors accepted so far, never passes exp_q
    logic [2:1]       vld_pipe;   // [1] stage-1 valid, [2] stage-2 valid
    vec_t             in_vec, s1_vec, s2_vec;
    logic [7:0]       s1_exp;
    logic             s2_match;
    logic             load, accept, stop;

    assign in_vec     = {opcode, a, b, rslt};
    assign s1_exp     = alu_ref(s1_vec.opcode, s1_vec.a, s1_vec.b);

    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign pass_pulse = vld_pipe[2] &&  s2_match;
    assign fail_pulse = vld_pipe[2] && !s2_match;

    // A start is only honoured outside RUN; it reloads the whole run context.
    assign load = start && (state != RUN);

`ifdef ALU_CHK_STOP_ON_FAIL_EN
    // The first mismatch aborts the run and flushes stage 1 on the same edge.
    assign stop = fail_pulse && (state == RUN);
`else
    assign stop = 1'b0;
`endif

    // Vectors past exp_count, or arriving on the abort edge, are dropped.
    assign accept = chk_valid && (state == RUN) && (acc_cnt != exp_q) && !stop;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) state_nxt = (exp_count == '0) ? DONE : RUN;
            end
            RUN: begin
                // Leaving as the last vector leaves stage 1 puts done in the
                // cycle right after that vector's pulse, with counts settled.
                if (stop || ((acc_cnt == exp_q) && !vld_pipe[1])) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            exp_q      <= '0;
            acc_cnt    <= '0;
            vld_pipe   <= '0;
            s1_vec     <= '0;
            s2_vec     <= '0;
            s2_match   <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            err_sticky <= 1'b0;
            first_fail <= '0;
        end else begin
            state       <= state_nxt;
            vld_pipe[1] <= accept;
            vld_pipe[2] <= vld_pipe[1] && !stop;

            if (accept) s1_vec <= in_vec;

            // The registered compare bit is all later logic needs of the
            // expected value; the vector travels along for first_fail.
            if (vld_pipe[1]) begin
                s2_vec   <= s1_vec;
                s2_match <= (s1_vec.rslt == s1_exp);
            end

            if (load) begin
                exp_q      <= exp_count;
                acc_cnt    <= '0;
                pass_cnt   <= '0;
                fail_cnt   <= '0;
                err_sticky <= 1'b0;
                first_fail <= '0;
            end else begin
                if (accept) acc_cnt <= acc_cnt + CNT_ONE;
                if (pass_pulse && (pass_cnt != CNT_MAX)) pass_cnt <= pass_cnt + CNT_ONE;
                if (fail_pulse && (fail_cnt != CNT_MAX)) fail_cnt <= fail_cnt + CNT_ONE;
                if (fail_pulse && !err_sticky) begin
                    err_sticky <= 1'b1;
                    first_fail <= s2_vec;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
module tb_alu_result_checker;

    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] exp_count = '0;
    logic             chk_valid = 1'b0;
    logic [3:0]       a = '0, b = '0;
    logic [2:0]       opcode = '0;
    logic [7:0]       rslt = '0;
    logic             busy, done, pass_pulse, fail_pulse, err_sticky;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;
    logic [18:0]      first_fail;

    alu_result_checker #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .exp_count(exp_count),
        .chk_valid(chk_valid), .a(a), .b(b), .opcode(opcode), .rslt(rslt),
        .busy(busy), .done(done), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_sticky(err_sticky),
        .first_fail(first_fail)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit pass; longint when; } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    longint done_rise = -1;

    // ---------------- reference model (run-level view) ----------------
    bit         m_active, m_stop, m_err;
    int         m_exp, m_acc, m_pass, m_fail;
    logic [18:0] m_ff;
    longint     m_done_cyc = 64'h7fff_ffff_ffff_ffff;

    function automatic logic [7:0] ref_alu(int op, int x, int y);
        int r;
        case (op)
            0:       r = x + y;
            1:       r = x - y;
            2:       r = x * y;
            3:       r = x & y;
            4:       r = x | y;
            5:       r = 15 - x;
            6:       r = x ^ y;
            default: r = 15 - (x ^ y);
        endcase
        return r[7:0];
    endfunction

    task automatic chk(string name, longint act, longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_start(int ec);
        if (m_active && cyc < m_done_cyc) return;   // start during a run is ignored
        m_active = 1; m_stop = 0; m_err = 0; m_ff = '0;
        m_exp = ec; m_acc = 0; m_pass = 0; m_fail = 0;
        m_done_cyc = (ec == 0) ? cyc + 1 : 64'h7fff_ffff_ffff_ffff;
    endtask

    task automatic model_vec(int op, int x, int y, int r);
        bit ok;
        if (!m_active || m_stop || m_acc >= m_exp) return;
        ok = (r[7:0] == ref_alu(op, x, y));
        sb.push_back('{ok, cyc + 2});
        m_acc++;
        if (ok) begin
            if (m_pass < CMAX) m_pass++;
        end else begin
            if (m_fail < CMAX) m_fail++;
            if (!m_err) begin
                m_err = 1;
                m_ff  = {op[2:0], x[3:0], y[3:0], r[7:0]};
            end
`ifdef ALU_CHK_STOP_ON_FAIL_EN
            m_stop = 1;
            m_done_cyc = cyc + 3;
`endif
        end
        if (m_acc == m_exp && !m_stop) m_done_cyc = cyc + 3;
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc_drive(bit st, int ec, bit v, int op, int x, int y, int r);
        @(posedge clk); #1;
        start = st; exp_count = CNT_W'(ec); chk_valid = v;
        opcode = op[2:0]; a = x[3:0]; b = y[3:0]; rslt = r[7:0];
        if (st) model_start(ec);
        if (v)  model_vec(op, x, y, r);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            cyc_drive(0, 0, 0, $urandom_range(0, 7), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 255));
    endtask

    task automatic rand_vec(bit good);
        int op = $urandom_range(0, 7);
        int x  = $urandom_range(0, 15);
        int y  = $urandom_range(0, 15);
        int r  = ref_alu(op, x, y);
        if (!good) r = r ^ $urandom_range(1, 255);
        cyc_drive(0, 0, 1, op, x, y, r);
    endtask

    task automatic finish_run(string tag);
        bit seen = 0;
        idle(1);
        for (int k = 0; k < 80 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        chk({tag, ".done_seen"}, seen, 1);
        if (seen) chk({tag, ".done_cycle"}, done_rise, m_done_cyc);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".pass_cnt"}, pass_cnt, m_pass);
        chk({tag, ".fail_cnt"}, fail_cnt, m_fail);
        chk({tag, ".err_sticky"}, err_sticky, m_err);
        chk({tag, ".first_fail"}, first_fail, m_ff);
        chk({tag, ".sb_drained"}, sb.size(), 0);
    endtask

    task automatic check_zero(string tag);
        @(negedge clk);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".pulses"}, {pass_pulse, fail_pulse}, 0);
        chk({tag, ".pass_cnt"}, pass_cnt, 0);
        chk({tag, ".fail_cnt"}, fail_cnt, 0);
        chk({tag, ".err_sticky"}, err_sticky, 0);
        chk({tag, ".first_fail"}, first_fail, 0);
    endtask

    // ---------------- monitor: pops the scoreboard on every pulse ----------------
    initial begin : monitor
        exp_t e;
        bit   prev_done = 0;
        forever begin
            @(negedge clk);
            if (done && !prev_done) done_rise = cyc;
            prev_done = done;
            if (pass_pulse || fail_pulse) begin
                chk("pulse_onehot", pass_pulse & fail_pulse, 0);
                chk("pulse_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pulse_kind_pass", pass_pulse, e.pass);
                    chk("pulse_cycle", cyc, e.when);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check_zero("reset");

        // chk_valid while IDLE: no pulses, no counts
        cyc_drive(0, 0, 1, 0, 1, 2, 3);
        idle(3);

        // exp_count = 0 goes straight to DONE
        cyc_drive(1, 0, 0, 0, 0, 0, 0);
        finish_run("exp0");

        // two back-to-back passing adds
        cyc_drive(1, 2, 0, 0, 0, 0, 0);
        cyc_drive(0, 0, 1, 0, 1, 2, 8'h03);
        cyc_drive(0, 0, 1, 0, 6, 6, 8'h0C);
        finish_run("add2");

        // chk_valid in DONE is ignored; counts unchanged
        cyc_drive(0, 0, 1, 0, 1, 1, 8'h07);
        idle(3);
        finish_run("done_ignore");

        // sub/mul/not/xnor, with a stray start mid-run
        cyc_drive(1, 5, 0, 0, 0, 0, 0);
        cyc_drive(0, 0, 1, 1, 12, 3, 8'h09);
        cyc_drive(0, 0, 1, 1, 3, 5, 8'hFE);
        cyc_drive(1, 1, 0, 0, 0, 0, 0);
        cyc_drive(0, 0, 1, 2, 15, 3, 8'h2D);
        cyc_drive(0, 0, 1, 5, 9, 4'hA, 8'h06);
        cyc_drive(0, 0, 1, 7, 3, 14, 8'h02);
        finish_run("mixed");

        // mismatch then one good vector
        cyc_drive(1, 2, 0, 0, 0, 0, 0);
        cyc_drive(0, 0, 1, 3, 12, 7, 8'h05);
        cyc_drive(0, 0, 1, 0, 2, 2, 8'h04);
        finish_run("mismatch");

        // full-scale run plus extras beyond exp_count
        cyc_drive(1, CMAX, 0, 0, 0, 0, 0);
        for (int i = 0; i < CMAX + 2; i++) rand_vec(1);
        finish_run("fullscale");

        // reset while a vector sits in stage 1
        cyc_drive(1, 4, 0, 0, 0, 0, 0);
        cyc_drive(0, 0, 1, 0, 3, 4, 8'h07);
        @(posedge clk); #1;
        rst_n = 0; chk_valid = 0;
        sb.delete();
        m_active = 0;
        m_done_cyc = 64'h7fff_ffff_ffff_ffff;
        @(posedge clk); #1;
        rst_n = 1;
        check_zero("midrun_reset");
        idle(4);

        // randomized runs
        for (int run = 0; run < 25; run++) begin
            int ec = $urandom_range(1, 12);
            int nv = ec + $urandom_range(0, 3);
            cyc_drive(1, ec, 0, 0, 0, 0, 0);
            for (int i = 0; i < nv; i++) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
                rand_vec($urandom_range(0, 4) != 0);
            end
            finish_run("random");
            if ($urandom_range(0, 1) == 1) begin
                rand_vec(1);
                idle(2);
            end
        end

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
